// File: rtl/turnstile_pkg.sv
// turnstile_pkg: shared gate FSM encoding and default sizing for turnstile controllers
package turnstile_pkg;
  localparam int DEF_N_READERS = 4;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    UNLOCKED = 3'b010,
    HOLDOFF = 3'b100
  } gate_fsm_t;
endpackage

// File: rtl/turnstile_gate_arbiter_if.sv
// turnstile_gate_arbiter_if: reader requests, push sensor and gate status bundle
interface turnstile_gate_arbiter_if #(
  parameter int N_READERS = turnstile_pkg::DEF_N_READERS,
  parameter int CNT_W = turnstile_pkg::DEF_CNT_W
) ();
  logic [N_READERS-1:0] req_i;
  logic push_i;
  logic [N_READERS-1:0] ack_o;
  logic [N_READERS-1:0] grant_o;
  logic locked_o;
  logic unlocked_o;
  logic timeout_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] timeout_cnt_o;
  modport master (
    output req_i, push_i,
    input ack_o, grant_o, locked_o, unlocked_o, timeout_o, pass_cnt_o, timeout_cnt_o
  );
  modport slave (
    input req_i, push_i,
    output ack_o, grant_o, locked_o, unlocked_o, timeout_o, pass_cnt_o, timeout_cnt_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr cyclically
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic found;
  int k;
  assign any = |req;
  // scan from ptr, wrapping, and keep the first hit
  always_comb begin
    winner = '0;
    idx = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found = 1'b1;
        winner[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/turnstile_gate_arbiter.sv
// turnstile_gate_arbiter: round-robin ownership of one turnstile with unlock timeout and counters
module turnstile_gate_arbiter
  import turnstile_pkg::*;
#(
  parameter int N_READERS = DEF_N_READERS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W = DEF_CNT_W,
  localparam int PW = $clog2(N_READERS),
  localparam int TW = $clog2(TIMEOUT_CYC)
) (
  input logic clk_i,
  input logic rst_ni,
  turnstile_gate_arbiter_if.slave bus
);
  gate_fsm_t state, state_d;
  logic [N_READERS-1:0] grant, grant_d, ack, ack_d, win;
  logic timeout, timeout_d, any;
  logic [TW-1:0] timer, timer_d;
  logic [PW-1:0] ptr, ptr_d, idx;
  logic [CNT_W-1:0] pass_cnt, pass_d, to_cnt, to_d;

  rr_arbiter #(.N(N_READERS)) u_arb (
    .req(bus.req_i),
    .ptr(ptr),
    .winner(win),
    .idx(idx),
    .any(any)
  );

  // state and every output-facing register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= '0;
      ack <= '0;
      timeout <= 1'b0;
      timer <= '0;
      ptr <= '0;
      pass_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ack <= ack_d;
      timeout <= timeout_d;
      timer <= timer_d;
      ptr <= ptr_d;
      pass_cnt <= pass_d;
      to_cnt <= to_d;
    end
  end

  // next state; an illegal encoding behaves as IDLE, and push beats timeout
  always_comb begin
    state_d = IDLE;
    grant_d = '0;
    ack_d = '0;
    timeout_d = 1'b0;
    timer_d = timer;
    ptr_d = ptr;
    pass_d = pass_cnt;
    to_d = to_cnt;
    case (state)
      UNLOCKED: begin
        if (bus.push_i) begin
          state_d = HOLDOFF;
          pass_d = pass_cnt + 1'b1;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_d = HOLDOFF;
          timeout_d = 1'b1;
          to_d = to_cnt + 1'b1;
        end else begin
          state_d = UNLOCKED;
          grant_d = grant;
          timer_d = timer + 1'b1;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: begin
        if (any) begin
          state_d = UNLOCKED;
          grant_d = win;
          ack_d = win;
          timer_d = '0;
          ptr_d = (int'(idx) == N_READERS - 1) ? '0 : idx + 1'b1;
        end
      end
    endcase
  end

  assign bus.grant_o = grant;
  assign bus.ack_o = ack;
  assign bus.timeout_o = timeout;
  assign bus.pass_cnt_o = pass_cnt;
  assign bus.timeout_cnt_o = to_cnt;
  assign bus.unlocked_o = (state == UNLOCKED);
  assign bus.locked_o = (state != UNLOCKED);
endmodule

// File: tb/tb_turnstile_gate_arbiter.sv
// tb_turnstile_gate_arbiter: directed checks of grant order, timeout, wrap and async reset
module tb_turnstile_gate_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] order [5];

  turnstile_gate_arbiter_if #(.N_READERS(4), .CNT_W(8)) bus ();

  turnstile_gate_arbiter #(.N_READERS(4), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    bus.req_i = '0;
    bus.push_i = 1'b0;
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    do_reset();
    step();
    step();
    chk("rst_locked", bus.locked_o, 1);
    chk("rst_unlocked", bus.unlocked_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_pass", bus.pass_cnt_o, 0);
    chk("rst_tocnt", bus.timeout_cnt_o, 0);

    bus.req_i = 4'b0100;
    step();
    chk("t2_grant", bus.grant_o, 4'b0100);
    chk("t2_ack", bus.ack_o, 4'b0100);
    chk("t2_unlocked", bus.unlocked_o, 1);
    bus.req_i = '0;
    step();
    chk("t2_ack_pulse", bus.ack_o, 0);
    chk("t2_grant_held", bus.grant_o, 4'b0100);
    bus.push_i = 1'b1;
    step();
    bus.push_i = 1'b0;
    chk("t2_locked", bus.locked_o, 1);
    chk("t2_pass", bus.pass_cnt_o, 1);
    chk("t2_grant_clr", bus.grant_o, 0);
    step();
    chk("t2_idle_locked", bus.locked_o, 1);
    chk("t2_idle_grant", bus.grant_o, 0);

    do_reset();
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_grant%0d", i), bus.grant_o, order[i]);
      bus.push_i = 1'b1;
      step();
      bus.push_i = 1'b0;
      step();
    end
    bus.req_i = '0;
    chk("t3_pass", bus.pass_cnt_o, 5);

    do_reset();
    bus.req_i = 4'b0010;
    step();
    bus.req_i = '0;
    chk("t4_grant", bus.grant_o, 4'b0010);
    repeat (15) step();
    chk("t4_unlock16", bus.unlocked_o, 1);
    chk("t4_no_early_to", bus.timeout_o, 0);
    step();
    chk("t4_timeout", bus.timeout_o, 1);
    chk("t4_tocnt", bus.timeout_cnt_o, 1);
    chk("t4_grant_clr", bus.grant_o, 0);
    chk("t4_locked", bus.locked_o, 1);
    step();
    chk("t4_to_pulse", bus.timeout_o, 0);
    bus.req_i = 4'b0010;
    step();
    bus.req_i = '0;
    chk("t4b_grant", bus.grant_o, 4'b0010);
    repeat (15) step();
    chk("t4b_unlock16", bus.unlocked_o, 1);
    bus.push_i = 1'b1;
    step();
    bus.push_i = 1'b0;
    chk("t4b_no_timeout", bus.timeout_o, 0);
    chk("t4b_pass", bus.pass_cnt_o, 1);
    chk("t4b_tocnt", bus.timeout_cnt_o, 1);
    step();

    bus.push_i = 1'b1;
    repeat (3) step();
    bus.push_i = 1'b0;
    chk("t5_idle_push_pass", bus.pass_cnt_o, 1);
    chk("t5_idle_push_to", bus.timeout_cnt_o, 1);
    bus.req_i = 4'b0001;
    step();
    bus.req_i = '0;
    chk("t5_grant", bus.grant_o, 4'b0001);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_async_grant", bus.grant_o, 0);
    chk("t5_async_locked", bus.locked_o, 1);
    chk("t5_async_unlocked", bus.unlocked_o, 0);
    chk("t5_async_pass", bus.pass_cnt_o, 0);
    chk("t5_async_to", bus.timeout_cnt_o, 0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 255; i++) begin
      bus.req_i = 4'b0001;
      step();
      bus.req_i = '0;
      bus.push_i = 1'b1;
      step();
      bus.push_i = 1'b0;
      step();
    end
    chk("t6_pass255", bus.pass_cnt_o, 255);
    bus.req_i = 4'b1000;
    step();
    bus.req_i = '0;
    bus.push_i = 1'b1;
    step();
    bus.push_i = 1'b0;
    chk("t6_pass_wrap", bus.pass_cnt_o, 0);
    chk("t6_tocnt", bus.timeout_cnt_o, 0);
    step();

    for (int i = 0; i < 300; i++) begin
      bus.req_i = 4'($urandom);
      bus.push_i = ($urandom_range(0, 3) == 0);
      step();
      chk("rnd_onehot", $onehot0(bus.grant_o), 1);
      chk("rnd_grant_unlocked", (bus.grant_o != 0), bus.unlocked_o);
      chk("rnd_ack_in_grant", bus.ack_o & ~bus.grant_o, 0);
    end
    bus.req_i = '0;
    bus.push_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
